// File: rtl/split_mem_target.sv
// Byte-wide memory target with optional split reads.
// Define SPLIT_MEM_TARGET_SPLIT_EN to enable split reads (wait, request bus, then return data).
module split_mem_target #(
    parameter int MEM_SIZE     = 4096,
    parameter int READ_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] target_addr_in,
    input  logic        target_addr_in_valid,
    input  logic [7:0]  target_data_in,
    input  logic        target_data_in_valid,
    input  logic        target_rw,
    output logic [7:0]  target_data_out,
    output logic        target_data_out_valid,
    output logic        target_ack,
    output logic        target_split_ack,
    output logic        target_ready,
    output logic        split_req,
    input  logic        split_grant,
    output logic [7:0]  split_target_last_write
);

    localparam int         ADDR_W = $clog2(MEM_SIZE);
    localparam logic [7:0] LAT    = 8'(READ_LATENCY);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WDATA      = 3'd1,
        WACK       = 3'd2,
        SPLIT_WAIT = 3'd3,
        SPLIT_REQ  = 3'd4,
        RDATA      = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              data_out_valid_q, data_out_valid_d;
    logic              ack_q, ack_d;
    logic              split_ack_q, split_ack_d;
    logic              ready_q, ready_d;
    logic              split_req_q, split_req_d;
    logic [7:0]        last_write_q, last_write_d;
    logic              mem_we_s;
    logic [7:0]        mem_q [MEM_SIZE];
`ifdef SPLIT_MEM_TARGET_SPLIT_EN
    logic [7:0]        cnt_q, cnt_d;
`endif

    // Upper address bits are deliberately dropped; grant and latency unused in some builds.
    logic unused_s;
    assign unused_s = &{1'b0, split_grant, LAT, target_addr_in[15:ADDR_W]};

    // Next-state, datapath and next-output computation.
    always_comb begin
        state_d      = state_q;
        offset_d     = offset_q;
        data_out_d   = data_out_q;
        last_write_d = last_write_q;
        mem_we_s     = 1'b0;
`ifdef SPLIT_MEM_TARGET_SPLIT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (target_addr_in_valid) begin
                    offset_d = target_addr_in[ADDR_W-1:0];
                    if (target_rw) begin
                        if (target_data_in_valid) begin
                            state_d      = WACK;
                            mem_we_s     = 1'b1;
                            last_write_d = target_data_in;
                        end else begin
                            state_d = WDATA;
                        end
                    end else begin
`ifdef SPLIT_MEM_TARGET_SPLIT_EN
                        state_d = SPLIT_WAIT;
                        cnt_d   = LAT;
`else
                        state_d    = RDATA;
                        data_out_d = mem_q[target_addr_in[ADDR_W-1:0]];
`endif
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WDATA: begin
                if (target_data_in_valid) begin
                    state_d      = WACK;
                    mem_we_s     = 1'b1;
                    last_write_d = target_data_in;
                end else begin
                    state_d = WDATA;
                end
            end
            WACK: state_d = IDLE;
`ifdef SPLIT_MEM_TARGET_SPLIT_EN
            SPLIT_WAIT: begin
                if (cnt_q == 8'd1) begin
                    state_d = SPLIT_REQ;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SPLIT_REQ: begin
                if (split_grant) begin
                    state_d    = RDATA;
                    data_out_d = mem_q[offset_q];
                end else begin
                    state_d = SPLIT_REQ;
                end
            end
`endif
            RDATA:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are a function of the state being entered, so they appear registered in that state.
        ready_d          = (state_d == IDLE);
        ack_d            = (state_d == WACK) || (state_d == RDATA);
        data_out_valid_d = (state_d == RDATA);
`ifdef SPLIT_MEM_TARGET_SPLIT_EN
        split_ack_d      = (state_q == IDLE) && (state_d == SPLIT_WAIT);
        split_req_d      = (state_d == SPLIT_REQ);
`else
        split_ack_d      = 1'b0;
        split_req_d      = 1'b0;
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            offset_q         <= '0;
            data_out_q       <= 8'd0;
            data_out_valid_q <= 1'b0;
            ack_q            <= 1'b0;
            split_ack_q      <= 1'b0;
            ready_q          <= 1'b1;
            split_req_q      <= 1'b0;
            last_write_q     <= 8'd0;
`ifdef SPLIT_MEM_TARGET_SPLIT_EN
            cnt_q            <= 8'd0;
`endif
        end else begin
            state_q          <= state_d;
            offset_q         <= offset_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            ack_q            <= ack_d;
            split_ack_q      <= split_ack_d;
            ready_q          <= ready_d;
            split_req_q      <= split_req_d;
            last_write_q     <= last_write_d;
`ifdef SPLIT_MEM_TARGET_SPLIT_EN
            cnt_q            <= cnt_d;
`endif
        end
    end

    // Memory array; contents survive reset, but no write lands while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
            mem_q[offset_d] <= last_write_d;
        end
    end

    assign target_data_out         = data_out_q;
    assign target_data_out_valid   = data_out_valid_q;
    assign target_ack              = ack_q;
    assign target_split_ack        = split_ack_q;
    assign target_ready            = ready_q;
    assign split_req               = split_req_q;
    assign split_target_last_write = last_write_q;

endmodule

// File: tb/tb_split_mem_target.sv
// Directed, table-driven bench for split_mem_target; follows SPLIT_MEM_TARGET_SPLIT_EN.
module tb_split_mem_target;

    localparam int RL = 4;

    logic        clk;
    logic        rst;
    logic [15:0] addr_in;
    logic        addr_valid;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        rw;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic        ack;
    logic        split_ack;
    logic        ready;
    logic        split_req;
    logic        split_grant;
    logic [7:0]  last_write;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_last;

    split_mem_target #(.MEM_SIZE(4096), .READ_LATENCY(RL)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .target_addr_in          (addr_in),
        .target_addr_in_valid    (addr_valid),
        .target_data_in          (data_in),
        .target_data_in_valid    (data_valid),
        .target_rw               (rw),
        .target_data_out         (data_out),
        .target_data_out_valid   (data_out_valid),
        .target_ack              (ack),
        .target_split_ack        (split_ack),
        .target_ready            (ready),
        .split_req               (split_req),
        .split_grant             (split_grant),
        .split_target_last_write (last_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_write;
        logic [15:0] addr;
        logic [7:0]  data;
        int          dly;
        int          hold;
    } vec_t;

    vec_t vecs [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int dly);
        chk("wr_ready_idle", 16'(ready), 16'd1);
        addr_in    = a;
        addr_valid = 1'b1;
        rw         = 1'b1;
        data_in    = d;
        data_valid = (dly == 0);
        step();
        addr_valid = 1'b0;
        data_valid = 1'b0;
        if (dly > 0) begin
            for (int k = 1; k < dly; k++) begin
                chk("wr_wait_ready", 16'(ready), 16'd0);
                chk("wr_wait_ack", 16'(ack), 16'd0);
                step();
            end
            chk("wr_wait_ready", 16'(ready), 16'd0);
            data_valid = 1'b1;
            step();
            data_valid = 1'b0;
        end
        exp_last = d;
        chk("wr_ack", 16'(ack), 16'd1);
        chk("wr_last_write", 16'(last_write), 16'(d));
        chk("wr_ready_busy", 16'(ready), 16'd0);
        chk("wr_no_valid", 16'(data_out_valid), 16'd0);
        step();
        chk("wr_ready_back", 16'(ready), 16'd1);
        chk("wr_ack_pulse", 16'(ack), 16'd0);
    endtask

    // Drives the read up to the cycle in which data and ack are expected.
    task automatic start_read(input logic [15:0] a, input int hold);
        chk("rd_ready_idle", 16'(ready), 16'd1);
        addr_in    = a;
        addr_valid = 1'b1;
        rw         = 1'b0;
`ifndef SPLIT_MEM_TARGET_SPLIT_EN
        split_grant = 1'b1;
`endif
        step();
        addr_valid  = 1'b0;
        split_grant = 1'b0;
`ifdef SPLIT_MEM_TARGET_SPLIT_EN
        for (int w = 1; w <= RL; w++) begin
            chk("rd_split_ack", 16'(split_ack), (w == 1) ? 16'd1 : 16'd0);
            chk("rd_wait_req", 16'(split_req), 16'd0);
            chk("rd_wait_ack", 16'(ack), 16'd0);
            chk("rd_wait_ready", 16'(ready), 16'd0);
            if (w == 1) split_grant = 1'b1;
            if (w == 2) begin
                addr_valid = 1'b1;
                rw         = 1'b1;
                data_in    = 8'hEE;
                data_valid = 1'b1;
            end
            step();
            split_grant = 1'b0;
            addr_valid  = 1'b0;
            data_valid  = 1'b0;
        end
        for (int h = 1; h <= hold; h++) begin
            chk("rd_req_held", 16'(split_req), 16'd1);
            chk("rd_req_ack", 16'(ack), 16'd0);
            if (h == hold) split_grant = 1'b1;
            step();
            split_grant = 1'b0;
        end
`endif
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] exp, input int hold);
        start_read(a, hold);
        chk("rd_ack", 16'(ack), 16'd1);
        chk("rd_valid", 16'(data_out_valid), 16'd1);
        chk("rd_data", 16'(data_out), 16'(exp));
        chk("rd_req_low", 16'(split_req), 16'd0);
        chk("rd_split_ack_low", 16'(split_ack), 16'd0);
        chk("rd_last_write", 16'(last_write), 16'(exp_last));
        step();
        chk("rd_ready_back", 16'(ready), 16'd1);
        chk("rd_ack_pulse", 16'(ack), 16'd0);
        chk("rd_valid_pulse", 16'(data_out_valid), 16'd0);
        chk("rd_data_hold", 16'(data_out), 16'(exp));
    endtask

    initial begin
        rst         = 1'b1;
        addr_in     = 16'd0;
        addr_valid  = 1'b0;
        data_in     = 8'd0;
        data_valid  = 1'b0;
        rw          = 1'b0;
        split_grant = 1'b0;
        exp_last    = 8'd0;

        vecs[0]  = '{1'b1, 16'h4010, 8'hA5, 0, 0};
        vecs[1]  = '{1'b1, 16'h0020, 8'h3C, 3, 0};
        vecs[2]  = '{1'b0, 16'h4010, 8'hA5, 0, 5};
        vecs[3]  = '{1'b0, 16'h5010, 8'hA5, 0, 1};
        vecs[4]  = '{1'b0, 16'h0020, 8'h3C, 0, 2};
        vecs[5]  = '{1'b1, 16'h0FFF, 8'h5A, 1, 0};
        vecs[6]  = '{1'b0, 16'hFFFF, 8'h5A, 0, 3};
        vecs[7]  = '{1'b1, 16'h1000, 8'h77, 0, 0};
        vecs[8]  = '{1'b0, 16'h0000, 8'h77, 0, 1};
        vecs[9]  = '{1'b1, 16'h0021, 8'hC3, 2, 0};
        vecs[10] = '{1'b0, 16'h0021, 8'hC3, 0, 1};
        vecs[11] = '{1'b0, 16'h0020, 8'h3C, 0, 1};

        repeat (3) step();
        rst = 1'b0;
        chk("rst_ready", 16'(ready), 16'd1);
        chk("rst_data_out", 16'(data_out), 16'd0);
        chk("rst_valid", 16'(data_out_valid), 16'd0);
        chk("rst_ack", 16'(ack), 16'd0);
        chk("rst_split_ack", 16'(split_ack), 16'd0);
        chk("rst_split_req", 16'(split_req), 16'd0);
        chk("rst_last_write", 16'(last_write), 16'd0);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_write)
                do_write(vecs[i].addr, vecs[i].data, vecs[i].dly);
            else
                do_read(vecs[i].addr, vecs[i].data, vecs[i].hold);
        end

        // Write strobe during the read-data cycle must be ignored.
        start_read(16'h0020, 1);
        chk("seq_rdata_ack", 16'(ack), 16'd1);
        addr_in    = 16'h0020;
        addr_valid = 1'b1;
        rw         = 1'b1;
        data_in    = 8'hEE;
        data_valid = 1'b1;
        step();
        addr_valid = 1'b0;
        data_valid = 1'b0;
        chk("seq_strobe_ready", 16'(ready), 16'd1);
        chk("seq_strobe_ack", 16'(ack), 16'd0);
        chk("seq_strobe_last", 16'(last_write), 16'(exp_last));
        do_read(16'h0020, 8'h3C, 1);

`ifdef SPLIT_MEM_TARGET_SPLIT_EN
        // Reset while the split request is outstanding.
        addr_in    = 16'h4010;
        addr_valid = 1'b1;
        rw         = 1'b0;
        step();
        addr_valid = 1'b0;
        repeat (RL) step();
        chk("seq_req_before_rst", 16'(split_req), 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
`else
        // Reset while a write waits for data; data offered under reset must not land.
        addr_in    = 16'h0010;
        addr_valid = 1'b1;
        rw         = 1'b1;
        data_valid = 1'b0;
        step();
        addr_valid = 1'b0;
        chk("seq_wdata_ready", 16'(ready), 16'd0);
        rst        = 1'b1;
        data_in    = 8'hEE;
        data_valid = 1'b1;
        step();
        rst        = 1'b0;
        data_valid = 1'b0;
`endif
        exp_last = 8'd0;
        chk("seq_rst_req", 16'(split_req), 16'd0);
        chk("seq_rst_ready", 16'(ready), 16'd1);
        chk("seq_rst_ack", 16'(ack), 16'd0);
        chk("seq_rst_last", 16'(last_write), 16'd0);
        do_read(16'h0010, 8'hA5, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
